// File: rtl/mega_ctx_xfer.sv
// Context save/restore engine: moves FIRST_REG..LAST_REG between the core
// register file and data RAM, one byte per register, stalling the core while busy.
module mega_ctx_xfer #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_save,
  input  logic              start_restore,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rf_rd_addr,
  output logic              rf_read,
  output logic              rf_rd_16bit,
  input  logic [15:0]       rf_rd_data,
  output logic [4:0]        rf_rw_addr,
  output logic [15:0]       rf_rw_data,
  output logic              rf_rw_16bit,
  output logic              rf_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam logic [4:0]        FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0]        LAST_IDX  = 5'(LAST_REG);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RREQ,
    S_RWR,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [4:0]        r_idx;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_hold;
  logic              w_idx_last;
  logic              w_unused_rd_hi;

  assign w_idx_last     = (r_idx == LAST_IDX);
  assign w_unused_rd_hi = ^rf_rd_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // idx saturates at LAST_REG; the state change alone ends the transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_ptr  <= '0;
      r_hold <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_save || start_restore) begin
            r_idx <= FIRST_IDX;
            r_ptr <= base_addr;
          end
        end
        S_SAVE: begin
          if (mem_ready) begin
            r_ptr <= r_ptr + PTR_ONE;
            if (!w_idx_last) r_idx <= r_idx + 5'd1;
          end
        end
        S_RREQ: begin
          if (mem_ready) r_hold <= mem_rdata;
        end
        S_RWR: begin
          r_ptr <= r_ptr + PTR_ONE;
          if (!w_idx_last) r_idx <= r_idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_save)         w_next = S_SAVE;
        else if (start_restore) w_next = S_RREQ;
      end
      S_SAVE:  if (mem_ready && w_idx_last) w_next = S_DONE;
      S_RREQ:  if (mem_ready) w_next = S_RWR;
      S_RWR:   w_next = w_idx_last ? S_DONE : S_RREQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    rf_rd_addr  = '0;
    rf_read     = 1'b0;
    rf_rd_16bit = 1'b0;
    rf_rw_addr  = '0;
    rf_rw_data  = '0;
    rf_rw_16bit = 1'b0;
    rf_write    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    case (r_state)
      S_SAVE: begin
        rf_read    = 1'b1;
        rf_rd_addr = r_idx;
        mem_wr     = 1'b1;
        mem_addr   = r_ptr;
        mem_wdata  = rf_rd_data[7:0];
      end
      S_RREQ: begin
        mem_rd   = 1'b1;
        mem_addr = r_ptr;
      end
      S_RWR: begin
        rf_write   = 1'b1;
        rf_rw_addr = r_idx;
        rf_rw_data = {8'h00, r_hold};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mega_ctx_xfer.sv
// Bench for mega_ctx_xfer: regfile/RAM models around a full-range and an R24..R31 instance,
// with expected RAM and regfile writes queued at stimulus time and compared as they occur.
module tb_mega_ctx_xfer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_save, start_restore, busy, done;
  logic [15:0] base_addr, rf_rd_data, rf_rw_data, mem_addr;
  logic [4:0]  rf_rd_addr, rf_rw_addr;
  logic        rf_read, rf_rd_16bit, rf_rw_16bit, rf_write, mem_wr, mem_rd, mem_ready;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        start_save_h, start_restore_h, busy_h, done_h;
  logic [15:0] base_addr_h, rf_rd_data_h, rf_rw_data_h, mem_addr_h;
  logic [4:0]  rf_rd_addr_h, rf_rw_addr_h;
  logic        rf_read_h, rf_rd_16bit_h, rf_rw_16bit_h, rf_write_h, mem_wr_h, mem_rd_h, mem_ready_h;
  logic [7:0]  mem_wdata_h, mem_rdata_h;

  mega_ctx_xfer #(.FIRST_REG(0), .LAST_REG(31), .ADDR_W(16)) u_dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .busy(busy), .done(done),
    .rf_rd_addr(rf_rd_addr), .rf_read(rf_read), .rf_rd_16bit(rf_rd_16bit), .rf_rd_data(rf_rd_data),
    .rf_rw_addr(rf_rw_addr), .rf_rw_data(rf_rw_data), .rf_rw_16bit(rf_rw_16bit), .rf_write(rf_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mega_ctx_xfer #(.FIRST_REG(24), .LAST_REG(31), .ADDR_W(16)) u_dut_hi (
    .clk(clk), .rst(rst), .start_save(start_save_h), .start_restore(start_restore_h),
    .base_addr(base_addr_h), .busy(busy_h), .done(done_h),
    .rf_rd_addr(rf_rd_addr_h), .rf_read(rf_read_h), .rf_rd_16bit(rf_rd_16bit_h), .rf_rd_data(rf_rd_data_h),
    .rf_rw_addr(rf_rw_addr_h), .rf_rw_data(rf_rw_data_h), .rf_rw_16bit(rf_rw_16bit_h), .rf_write(rf_write_h),
    .mem_addr(mem_addr_h), .mem_wdata(mem_wdata_h), .mem_wr(mem_wr_h), .mem_rd(mem_rd_h),
    .mem_rdata(mem_rdata_h), .mem_ready(mem_ready_h)
  );

  logic [7:0] rf [32];
  logic [7:0] ram [65536];
  logic [7:0] rf_h [32];
  logic [7:0] ram_h [256];
  int ld_rf = 0, ld_ram = 0, ld_rf_h = 0, ld_ram_h = 0;

  int n_chk = 0, n_pass = 0;
  int n_rfw = 0, n_rfw_h = 0, n_done = 0;
  logic [31:0] exp_mem [$];
  logic [31:0] exp_rf [$];
  logic [31:0] exp_rf_h [$];
  bit          ready_mode_h = 1'b0;
  bit          pend_h = 1'b0;
  logic [15:0] hold_addr_h = '0;

  function automatic logic [7:0] pat(input int p, input int n);
    case (p)
      1:       return 8'(32'h10 + n);
      3:       return 8'(32'hA0 ^ n);
      4:       return 8'h55;
      5:       return 8'h33;
      6:       return 8'(32'hC0 + n);
      7:       return 8'(32'h5A ^ n);
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  assign rf_rd_data   = {8'h00, rf[rf_rd_addr]};
  assign mem_rdata    = ram[mem_addr];
  assign rf_rd_data_h = {8'h00, rf_h[rf_rd_addr_h]};
  assign mem_rdata_h  = ram_h[mem_addr_h[7:0]];

  // Single writer for every model array: backdoor preload or DUT strobes
  always @(posedge clk) begin
    if (ld_rf != 0) for (int i = 0; i < 32; i++) rf[i] <= pat(ld_rf, i);
    else if (rf_write) rf[rf_rw_addr] <= rf_rw_data[7:0];
    if (ld_ram != 0) for (int i = 0; i < 256; i++) ram[16'(32'h0200 + i)] <= pat(ld_ram, i);
    else if (mem_wr && mem_ready) ram[mem_addr] <= mem_wdata;
    if (ld_rf_h != 0) for (int i = 0; i < 32; i++) rf_h[i] <= pat(ld_rf_h, i);
    else if (rf_write_h) rf_h[rf_rw_addr_h] <= rf_rw_data_h[7:0];
    if (ld_ram_h != 0) for (int i = 0; i < 256; i++) ram_h[i] <= pat(ld_ram_h, i);
    else if (mem_wr_h && mem_ready_h) ram_h[mem_addr_h[7:0]] <= mem_wdata_h;
  end

  always @(negedge clk) begin
    if (mem_wr && mem_ready) begin
      if (exp_mem.size() == 0) chk("mem_wr_unexpected", 32'(exp_mem.size()), 32'd1);
      else chk("save_wr", {1'b0, rf_read, rf_rd_16bit, rf_rd_addr, mem_addr, mem_wdata}, exp_mem.pop_front());
    end
    if (rf_write) begin
      n_rfw++;
      if (exp_rf.size() == 0) chk("rf_wr_unexpected", 32'(exp_rf.size()), 32'd1);
      else chk("restore_wr", {10'd0, rf_rw_16bit, rf_rw_addr, rf_rw_data}, exp_rf.pop_front());
    end
    if (done) n_done++;
    if (rf_write_h) begin
      n_rfw_h++;
      if (exp_rf_h.size() == 0) chk("rf_wr_h_unexpected", 32'(exp_rf_h.size()), 32'd1);
      else chk("t3_restore_wr", {10'd0, rf_rw_16bit_h, rf_rw_addr_h, rf_rw_data_h}, exp_rf_h.pop_front());
    end
    if (pend_h) chk("t3_hold_stable", {15'd0, mem_rd_h, mem_addr_h}, {15'd0, 1'b1, hold_addr_h});
    pend_h      = mem_rd_h && !mem_ready_h;
    hold_addr_h = mem_addr_h;
  end

  initial begin
    int rdy_cnt;
    rdy_cnt = 0;
    mem_ready_h = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cnt++;
      mem_ready_h = ready_mode_h ? (rdy_cnt % 3 == 0) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int rfp, input int ramp);
    ld_rf = rfp;
    ld_ram = ramp;
    tick();
    ld_rf = 0;
    ld_ram = 0;
  endtask

  task automatic pulse(input bit s, input bit r, input logic [15:0] b);
    start_save = s;
    start_restore = r;
    base_addr = b;
    tick();
    start_save = 1'b0;
    start_restore = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit got);
    cycles = 0;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy) cycles++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_save(input logic [15:0] base, input int p);
    for (int n = 0; n < 32; n++)
      exp_mem.push_back({1'b0, 1'b1, 1'b0, 5'(n), 16'(32'(base) + n), pat(p, n)});
  endtask

  initial begin
    int  cyc, rfw0, done0, bad;
    bit  got;
    logic [7:0] cur [32];
    rst = 1'b1; start_save = 1'b0; start_restore = 1'b0; base_addr = '0; mem_ready = 1'b1;
    start_save_h = 1'b0; start_restore_h = 1'b0; base_addr_h = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_strobes", {26'd0, busy, done, rf_read, rf_write, mem_wr, mem_rd}, 32'd0);
    chk("rst_addrs", {6'd0, rf_rd_addr, rf_rw_addr, mem_addr}, 32'd0);
    chk("rst_data", {8'd0, rf_rw_data, mem_wdata}, 32'd0);
    tick();
    rst = 1'b0;

    // 1: full save
    preload(1, 0);
    push_save(16'h0200, 1);
    pulse(1'b1, 1'b0, 16'h0200);
    wait_done(cyc, got);
    chk("t1_done", 32'(got), 32'd1);
    chk("t1_busy_cycles", 32'(cyc), 32'd33);
    @(negedge clk);
    chk("t1_idle_after", {30'd0, busy, done}, 32'd0);
    chk("t1_queue_empty", 32'(exp_mem.size()), 32'd0);
    bad = 0;
    for (int n = 0; n < 32; n++) if (ram[16'(32'h0200 + n)] !== pat(1, n)) bad++;
    chk("t1_ram_image", 32'(bad), 32'd0);

    // 2: full restore
    preload(2, 3);
    for (int n = 0; n < 32; n++) exp_rf.push_back({10'd0, 1'b0, 5'(n), 8'h00, pat(3, n)});
    rfw0 = n_rfw;
    pulse(1'b0, 1'b1, 16'h0200);
    wait_done(cyc, got);
    chk("t2_done", 32'(got), 32'd1);
    chk("t2_busy_cycles", 32'(cyc), 32'd65);
    chk("t2_write_count", 32'(n_rfw - rfw0), 32'd32);
    bad = 0;
    tick();
    for (int n = 0; n < 32; n++) if (rf[n] !== pat(3, n)) bad++;
    chk("t2_regfile", 32'(bad), 32'd0);

    // 3: R24..R31 restore with RAM wait states
    ld_rf_h = 5; ld_ram_h = 3;
    tick();
    ld_rf_h = 0; ld_ram_h = 0;
    for (int k = 0; k < 8; k++) exp_rf_h.push_back({10'd0, 1'b0, 5'(24 + k), 8'h00, pat(3, 32'h40 + k)});
    ready_mode_h = 1'b1;
    start_restore_h = 1'b1; base_addr_h = 16'h0040;
    tick();
    start_restore_h = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done_h) got = 1'b1;
    end
    chk("t3_done", 32'(got), 32'd1);
    tick();
    ready_mode_h = 1'b0;
    chk("t3_write_count", 32'(n_rfw_h), 32'd8);
    chk("t3_queue_empty", 32'(exp_rf_h.size()), 32'd0);
    bad = 0;
    for (int n = 0; n < 24; n++) if (rf_h[n] !== 8'h33) bad++;
    chk("t3_low_untouched", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) if (rf_h[24 + k] !== pat(3, 32'h40 + k)) bad++;
    chk("t3_high_restored", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t3_idle", {26'd0, busy_h, rf_read_h, mem_wr_h, mem_rd_h, rf_write_h, rf_rd_16bit_h}, 32'd0);
    tick();

    // 4: simultaneous starts -> save; restore while busy ignored
    preload(6, 0);
    push_save(16'h0300, 6);
    rfw0 = n_rfw; done0 = n_done;
    pulse(1'b1, 1'b1, 16'h0300);
    tick(); tick();
    pulse(1'b0, 1'b1, 16'h0200);
    wait_done(cyc, got);
    chk("t4_done", 32'(got), 32'd1);
    repeat (6) tick();
    chk("t4_single_done", 32'(n_done - done0), 32'd1);
    chk("t4_no_restore", 32'(n_rfw - rfw0), 32'd0);
    chk("t4_queue_empty", 32'(exp_mem.size()), 32'd0);

    // 5: pointer wraps past 0xFFFF
    preload(1, 0);
    push_save(16'hFFFE, 1);
    pulse(1'b1, 1'b0, 16'hFFFE);
    wait_done(cyc, got);
    chk("t5_busy_cycles", 32'(cyc), 32'd33);
    tick();
    chk("t5_ram_fffe", 32'(ram[16'hFFFE]), 32'h10);
    chk("t5_ram_ffff", 32'(ram[16'hFFFF]), 32'h11);
    chk("t5_ram_0000", 32'(ram[16'h0000]), 32'h12);
    chk("t5_ram_0001", 32'(ram[16'h0001]), 32'h13);

    // 6: reset after five restored registers
    preload(4, 7);
    for (int n = 0; n < 32; n++) exp_rf.push_back({10'd0, 1'b0, 5'(n), 8'h00, pat(7, n)});
    rfw0 = n_rfw; done0 = n_done;
    pulse(1'b0, 1'b1, 16'h0200);
    bad = 0;
    for (int k = 0; k < 200 && bad < 5; k++) begin
      @(negedge clk);
      if (rf_write) bad++;
    end
    chk("t6_reached_five", 32'(bad), 32'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", {26'd0, busy, done, rf_read, rf_write, mem_wr, mem_rd}, 32'd0);
    repeat (5) tick();
    exp_rf.delete();
    chk("t6_no_done", 32'(n_done - done0), 32'd0);
    chk("t6_write_count", 32'(n_rfw - rfw0), 32'd5);
    bad = 0;
    for (int n = 0; n < 32; n++) begin
      cur[n] = (n < 5) ? pat(7, n) : 8'h55;
      if (rf[n] !== cur[n]) bad++;
    end
    chk("t6_regfile", 32'(bad), 32'd0);
    for (int n = 0; n < 32; n++)
      exp_mem.push_back({1'b0, 1'b1, 1'b0, 5'(n), 16'(32'h0400 + n), cur[n]});
    pulse(1'b1, 1'b0, 16'h0400);
    wait_done(cyc, got);
    chk("t6_resave_cycles", 32'(cyc), 32'd33);
    tick();
    chk("t6_resave_queue", 32'(exp_mem.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
